uart_tx_scheduler: RTL and testbench

- Shares the single UART byte transmitter between NUM_REQ byte producers, e.g. left/right camera status and disparity statistics.
- Each requester owns a 1-deep holding register with a valid/ready handshake. Requesters are served round-robin.
- Each byte can optionally be preceded by a tag byte that identifies its source.
- The transmitter has no busy output, so the scheduler paces it open-loop. It asserts transmit for exactly one baud period per byte, then waits out a fixed slot before the next byte.

---
 rtl/uart_tx_scheduler.sv | 225 ++++++++++++++++++++++
 tb/tb_uart_tx_scheduler.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_scheduler.sv
// -----------------------------------------------------------------------------
// uart_tx_scheduler
//
// Shares one UART byte transmitter between NUM_REQ byte producers. Each
// producer owns a 1-deep holding register behind a valid/ready handshake.
// Full registers are served round-robin. Each payload byte can be preceded by
// a tag byte {4'hA, 2'b00, id} that names its source.
//
// The transmitter has no busy output, so it is paced open-loop. Each byte
// occupies a fixed slot of SLOT_BITS bit periods. tx_transmit is high for the
// first bit period of the slot, and tx_data is held for the whole slot.
//
// Parameters
//   NUM_REQ    number of requesters (2..4)
//   BAUD_DIV   bit-period terminal count; one bit period = BAUD_DIV+1 clocks
//   SLOT_BITS  bit periods reserved per byte (frame + guard)
//   TAG_EN     1: send a tag byte before every payload byte
//
// Ports
//   clk          system clock
//   reset        asynchronous, active-low reset
//   req_valid    per-requester byte valid
//   req_data     per-requester byte, requester i on [8i+7:8i]
//   req_ready    holding register i empty (handshake on valid&ready)
//   tx_transmit  transmitter transmit strobe (one bit period per byte)
//   tx_data      transmitter data, stable for the whole slot
//   busy         scheduler not idle
//   grant_id     requester currently being served
// -----------------------------------------------------------------------------
module uart_tx_scheduler #(
    parameter int NUM_REQ   = 2,
    parameter int BAUD_DIV  = 10415,
    parameter int SLOT_BITS = 12,
    parameter bit TAG_EN    = 1'b1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [8*NUM_REQ-1:0] req_data,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic                 tx_transmit,
    output logic [7:0]           tx_data,
    output logic                 busy,
    output logic [1:0]           grant_id
);

    // Slot length in clocks and the counter width needed to reach its last
    // count.
    localparam int SLOT_LEN = SLOT_BITS * (BAUD_DIV + 1);
    localparam int CNT_W    = (SLOT_LEN > 1) ? $clog2(SLOT_LEN) : 1;

    localparam logic [CNT_W-1:0] SLOT_LAST = CNT_W'(SLOT_LEN - 1);
    localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(BAUD_DIV);
    localparam logic [1:0]       LAST_ID   = 2'(NUM_REQ - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ARB,
        S_TAG,
        S_DATA
    } state_e;

    // Registered state
    state_e             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [1:0]         ptr_q;
    logic [1:0]         grant_q;
    logic [NUM_REQ-1:0] full_q;
    logic [7:0]         hold_q [NUM_REQ];
    logic               tx_transmit_q;
    logic [7:0]         tx_data_q;
    logic               busy_q;

    // Combinational helpers
    logic [NUM_REQ-1:0] full_d;
    logic [NUM_REQ-1:0] grant_mask;
    logic [7:0]         grant_byte;
    logic               others_full;
    logic               slot_end;
    logic [1:0]         fwd_pick;
    logic               fwd_found;
    logic [1:0]         wrap_pick;
    logic [1:0]         pick;
    logic [7:0]         pick_byte;
    logic [1:0]         ptr_d;

    assign req_ready   = ~full_q;
    assign tx_transmit = tx_transmit_q;
    assign tx_data     = tx_data_q;
    assign busy        = busy_q;
    assign grant_id    = grant_q;

    // Holding-register occupancy. A capture and a clear never hit the same
    // bit, because a full register is not ready.
    always_comb begin
        // NOTE: every signal gets a default before any conditional update.
        // A path that leaves a signal unassigned in always_comb infers a latch.
        grant_mask = '0;
        grant_byte = 8'h00;
        for (int j = 0; j < NUM_REQ; j++) begin
            if (2'(j) == grant_q) begin
                grant_mask[j] = 1'b1;
                grant_byte    = hold_q[j];
            end
        end

        slot_end    = (cnt_q == SLOT_LAST);
        others_full = |(full_q & ~grant_mask);

        full_d = full_q | (req_valid & ~full_q);
        if (state_q == S_DATA && slot_end) begin
            full_d = full_d & ~grant_mask;
        end
    end

    // Round-robin pick. The first full requester at or above the pointer
    // wins. If there is none, the lowest full requester wins, which is the
    // wrap-around case. Scanning downward lets the last hit (lowest index)
    // stand.
    always_comb begin
        fwd_pick  = 2'd0;
        fwd_found = 1'b0;
        wrap_pick = 2'd0;
        for (int j = NUM_REQ - 1; j >= 0; j--) begin
            if (full_q[j]) begin
                wrap_pick = 2'(j);
            end
            if (full_q[j] && (2'(j) >= ptr_q)) begin
                fwd_pick  = 2'(j);
                fwd_found = 1'b1;
            end
        end
        pick = fwd_found ? fwd_pick : wrap_pick;

        pick_byte = 8'h00;
        for (int j = 0; j < NUM_REQ; j++) begin
            if (2'(j) == pick) begin
                pick_byte = hold_q[j];
            end
        end

        ptr_d = (pick == LAST_ID) ? 2'd0 : pick + 2'd1;
    end

    // Holding bytes are pure datapath. They are only read once full_q says
    // they are valid.
    // NOTE: storage that is qualified by a separate valid flag is left out of
    // reset. Only the control state needs a known value after reset.
    always_ff @(posedge clk) begin
        for (int j = 0; j < NUM_REQ; j++) begin
            if (req_valid[j] && !full_q[j]) begin
                hold_q[j] <= req_data[8*j +: 8];
            end
        end
    end

    // Scheduler FSM with registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= S_IDLE;
            cnt_q         <= '0;
            ptr_q         <= 2'd0;
            grant_q       <= 2'd0;
            full_q        <= '0;
            tx_transmit_q <= 1'b0;
            tx_data_q     <= 8'h00;
            busy_q        <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments. Every
            // register then samples pre-edge values, whatever the statement
            // order.
            full_q <= full_d;

            case (state_q)
                S_IDLE: begin
                    if (|full_q) begin
                        state_q <= S_ARB;
                        busy_q  <= 1'b1;
                    end
                end

                S_ARB: begin
                    grant_q       <= pick;
                    ptr_q         <= ptr_d;
                    cnt_q         <= '0;
                    tx_transmit_q <= 1'b1;
                    if (TAG_EN) begin
                        state_q   <= S_TAG;
                        tx_data_q <= {4'hA, 2'b00, pick};
                    end else begin
                        state_q   <= S_DATA;
                        tx_data_q <= pick_byte;
                    end
                end

                S_TAG, S_DATA: begin
                    if (!slot_end) begin
                        cnt_q <= cnt_q + 1'b1;
                        // Strobe covers counts 0..BAUD_DIV, one bit period.
                        tx_transmit_q <= (cnt_q < BAUD_LAST);
                    end else if (state_q == S_TAG) begin
                        state_q       <= S_DATA;
                        cnt_q         <= '0;
                        tx_transmit_q <= 1'b1;
                        tx_data_q     <= grant_byte;
                    end else begin
                        tx_transmit_q <= 1'b0;
                        if (others_full) begin
                            state_q <= S_ARB;
                        end else begin
                            state_q <= S_IDLE;
                            busy_q  <= 1'b0;
                        end
                    end
                end

                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_scheduler
//
// Directed bench for uart_tx_scheduler with BAUD_DIV=3, so one slot is
// 12*4 = 48 clocks. It uses two instances:
//   dut_a : NUM_REQ=2, TAG_EN=0
//   dut_b : NUM_REQ=4, TAG_EN=1
// A behavioural transmitter model logs every transmit pulse: its start cycle,
// the data byte seen at the start, and the width in clocks.
// -----------------------------------------------------------------------------
module tb_uart_tx_scheduler;

    localparam int BD = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // dut_a signals
    logic       rst_a;
    logic [1:0] va;
    logic [15:0] da;
    logic [1:0] ra;
    logic       ta;
    logic [7:0] xa;
    logic       ba;
    logic [1:0] ga;

    // dut_b signals
    logic       rst_b;
    logic [3:0] vb;
    logic [31:0] db;
    logic [3:0] rb;
    logic       tt_b;
    logic [7:0] xb;
    logic       bb;
    logic [1:0] gb;

    uart_tx_scheduler #(.NUM_REQ(2), .BAUD_DIV(BD), .SLOT_BITS(12), .TAG_EN(1'b0)) dut_a (
        .clk(clk), .reset(rst_a), .req_valid(va), .req_data(da), .req_ready(ra),
        .tx_transmit(ta), .tx_data(xa), .busy(ba), .grant_id(ga)
    );

    uart_tx_scheduler #(.NUM_REQ(4), .BAUD_DIV(BD), .SLOT_BITS(12), .TAG_EN(1'b1)) dut_b (
        .clk(clk), .reset(rst_b), .req_valid(vb), .req_data(db), .req_ready(rb),
        .tx_transmit(tt_b), .tx_data(xb), .busy(bb), .grant_id(gb)
    );

    // Transmitter model: one pulse log per instance.
    logic       mon_t [2];
    logic [7:0] mon_d [2];
    logic       mon_b [2];
    assign mon_t[0] = ta;   assign mon_d[0] = xa; assign mon_b[0] = ba;
    assign mon_t[1] = tt_b; assign mon_d[1] = xb; assign mon_b[1] = bb;

    int         np [2]       = '{0, 0};
    int         busy_cnt [2] = '{0, 0};
    logic       prev_t [2]   = '{1'b0, 1'b0};
    int         p_start [2][64];
    int         p_width [2][64];
    logic [7:0] p_data  [2][64];

    always @(negedge clk) begin
        for (int u = 0; u < 2; u++) begin
            if (mon_t[u] === 1'b1) begin
                if (prev_t[u] !== 1'b1 && np[u] < 64) begin
                    p_start[u][np[u]] = cyc;
                    p_data[u][np[u]]  = mon_d[u];
                    p_width[u][np[u]] = 0;
                    np[u]++;
                end
                if (np[u] > 0) p_width[u][np[u]-1]++;
            end
            prev_t[u] = mon_t[u];
            if (mon_b[u] === 1'b1) busy_cnt[u]++;
        end
    end

    int n_vec = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance n falling edges, then settle 1 time unit away from any edge.
    task automatic step(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic wait_np(input int u, input int target, input int budget, input string tag);
        int k;
        k = 0;
        while (np[u] < target && k < budget) begin
            step(1);
            k++;
        end
        check(tag, 32'(np[u] >= target), 32'd1);
    endtask

    task automatic wait_ready(input int bit_i, input int budget, input string tag);
        int k;
        k = 0;
        while (ra[bit_i] !== 1'b1 && k < budget) begin
            step(1);
            k++;
        end
        check(tag, 32'(ra[bit_i]), 32'd1);
    endtask

    task automatic wait_grant_b(input logic [1:0] g, input int budget, input string tag);
        int k;
        k = 0;
        while (gb !== g && k < budget) begin
            step(1);
            k++;
        end
        check(tag, 32'(gb), 32'(g));
    endtask

    logic [7:0] rr_exp [10];

    initial begin
        int c0;
        int base;
        int b0;
        int nb;
        int errs;

        rr_exp = '{8'hA0, 8'h10, 8'hA1, 8'h11, 8'hA2, 8'h12, 8'hA3, 8'h13, 8'hA0, 8'h20};

        rst_a = 1'b0; va = '0; da = '0;
        rst_b = 1'b0; vb = '0; db = '0;
        step(3);
        rst_a = 1'b1;
        rst_b = 1'b1;
        step(1);

        // ---------------- Reset state ----------------
        check("rst_a_ready", 32'(ra), 32'h3);
        check("rst_a_tx",    32'(ta), 32'h0);
        check("rst_a_data",  32'(xa), 32'h00);
        check("rst_a_busy",  32'(ba), 32'h0);
        check("rst_a_grant", 32'(ga), 32'h0);
        check("rst_b_ready", 32'(rb), 32'hF);
        check("rst_b_busy",  32'(bb), 32'h0);

        // ---------------- T1: single untagged byte ----------------
        va = 2'b01; da[7:0] = 8'h5A;
        step(1);
        va = '0;
        c0 = cyc;
        base = np[0];
        b0 = busy_cnt[0];
        check("t1_ready_low", 32'(ra[0]), 32'h0);
        step(60);
        check("t1_pulses", 32'(np[0] - base), 32'd1);
        check("t1_latency", 32'(p_start[0][base] - c0), 32'd2);
        check("t1_width", 32'(p_width[0][base]), 32'd4);
        check("t1_data", 32'(p_data[0][base]), 32'h5A);
        // One ARB clock plus the 48-clock slot.
        check("t1_busy_clocks", 32'(busy_cnt[0] - b0), 32'd49);
        check("t1_idle", 32'(ba), 32'h0);
        check("t1_ready_back", 32'(ra), 32'h3);

        // ---------------- T2: tagged byte on dut_b ----------------
        vb = 4'b0100; db[23:16] = 8'h3C;
        step(1);
        vb = '0;
        c0 = cyc;
        base = np[1];
        check("t2_ready_low", 32'(rb[2]), 32'h0);
        wait_np(1, base + 2, 120, "t2_two_pulses");
        check("t2_tag", 32'(p_data[1][base]), 32'hA2);
        check("t2_data", 32'(p_data[1][base+1]), 32'h3C);
        check("t2_latency", 32'(p_start[1][base] - c0), 32'd2);
        check("t2_gap", 32'(p_start[1][base+1] - p_start[1][base]), 32'd48);
        check("t2_tag_width", 32'(p_width[1][base]), 32'd4);
        check("t2_grant", 32'(gb), 32'd2);
        step(60);
        check("t2_data_width", 32'(p_width[1][base+1]), 32'd4);
        check("t2_idle", 32'(bb), 32'h0);

        // ---------------- T4: back-to-back on dut_a ----------------
        // The pointer is 1 after T1, so req1 is served before req0.
        va = 2'b11; da = {8'h41, 8'h40};
        step(1);
        va = '0;
        base = np[0];
        wait_ready(1, 200, "t4_ready1_rise");
        va[1] = 1'b1; da[15:8] = 8'h42;
        step(1);
        va = '0;
        wait_np(0, base + 3, 200, "t4_three_pulses");
        check("t4_first", 32'(p_data[0][base]), 32'h41);
        check("t4_second", 32'(p_data[0][base+1]), 32'h40);
        check("t4_third", 32'(p_data[0][base+2]), 32'h42);
        check("t4_gap1", 32'(p_start[0][base+1] - p_start[0][base]), 32'd49);
        check("t4_gap2", 32'(p_start[0][base+2] - p_start[0][base+1]), 32'd49);
        step(60);

        // ---------------- T5: asynchronous reset mid-slot ----------------
        va = 2'b11; da = {8'h78, 8'h77};
        step(1);
        va = '0;
        base = np[0];
        wait_np(0, base + 1, 20, "t5_pulse_start");
        step(2);
        check("t5_tx_high", 32'(ta), 32'h1);
        check("t5_data", 32'(xa), 32'h77);
        rst_a = 1'b0;
        #1;
        check("t5_tx_drop", 32'(ta), 32'h0);
        check("t5_busy_drop", 32'(ba), 32'h0);
        check("t5_ready_all", 32'(ra), 32'h3);
        step(1);
        rst_a = 1'b1;
        nb = np[0];
        step(120);
        check("t5_no_pulses", 32'(np[0] - nb), 32'd0);
        va = 2'b01; da[7:0] = 8'h99;
        step(1);
        va = '0;
        wait_np(0, nb + 1, 20, "t5_restart");
        check("t5_restart_data", 32'(p_data[0][nb]), 32'h99);
        step(60);

        // ---------------- T3: round-robin on dut_b ----------------
        rst_b = 1'b0;
        step(1);
        rst_b = 1'b1;
        step(1);
        vb = 4'hF; db = {8'h13, 8'h12, 8'h11, 8'h10};
        step(1);
        vb = '0;
        base = np[1];
        wait_grant_b(2'd1, 300, "t3_reach_req1");
        vb[0] = 1'b1; db[7:0] = 8'h20;
        step(1);
        vb = '0;
        check("t3_refill_captured", 32'(rb[0]), 32'h0);
        wait_np(1, base + 10, 800, "t3_ten_pulses");
        for (int i = 0; i < 10; i++) begin
            check($sformatf("t3_order%0d", i), 32'(p_data[1][base+i]), 32'(rr_exp[i]));
        end
        step(60);

        // ---------------- T6: data stability on dut_b ----------------
        vb = 4'b0010; db[15:8] = 8'h55;
        step(1);
        vb = '0;
        base = np[1];
        wait_np(1, base + 1, 20, "t6_tag_start");
        check("t6_tag", 32'(p_data[1][base]), 32'hA1);
        db[15:8] = 8'hAA;
        wait_np(1, base + 2, 80, "t6_data_start");
        errs = 0;
        for (int i = 0; i < 40; i++) begin
            if (xb !== 8'h55) errs++;
            step(1);
        end
        check("t6_stable", 32'(errs), 32'd0);
        check("t6_pulse_data", 32'(p_data[1][base+1]), 32'h55);
        check("t6_grant", 32'(gb), 32'd1);
        step(20);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
